// File: rtl/full_subtractor_pkg.sv
// full_subtractor_pkg: shared widths and register-stage result type
package full_subtractor_pkg;
  localparam int FSUB_DEFAULT_WIDTH = 1;
  localparam int FSUB_MAX_WIDTH = 64;
  typedef struct packed {
    logic bout;
    logic ovf;
    logic [FSUB_MAX_WIDTH-1:0] diff;
  } fsub_result_t;
endpackage

// File: rtl/full_subtractor_core_if.sv
// full_subtractor_core_if: operand/result bundle; ovf exists only with FULL_SUBTRACTOR_OVF_EN
interface full_subtractor_core_if
  import full_subtractor_pkg::*;
#(
  parameter int WIDTH = FSUB_DEFAULT_WIDTH
);
  logic in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic bin;
  logic out_valid;
  logic [WIDTH-1:0] diff;
  logic bout;
`ifdef FULL_SUBTRACTOR_OVF_EN
  logic ovf;
  modport master (output in_valid, a, b, bin, input out_valid, diff, bout, ovf);
  modport slave (input in_valid, a, b, bin, output out_valid, diff, bout, ovf);
`else
  modport master (output in_valid, a, b, bin, input out_valid, diff, bout);
  modport slave (input in_valid, a, b, bin, output out_valid, diff, bout);
`endif
endinterface

// File: rtl/fsub_bit.sv
// fsub_bit: combinational 1-bit full subtractor cell
module fsub_bit (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

// File: rtl/full_subtractor_core.sv
// full_subtractor_core: registered ripple-borrow a-b-bin; FULL_SUBTRACTOR_OVF_EN adds signed ovf
module full_subtractor_core
  import full_subtractor_pkg::*;
#(
  parameter int WIDTH = FSUB_DEFAULT_WIDTH
) (
  input logic clk,
  input logic rst_n,
  full_subtractor_core_if.slave io
);
  if (WIDTH < 1 || WIDTH > FSUB_MAX_WIDTH) begin : g_bad_width
    $error("full_subtractor_core: WIDTH must be 1..64");
  end
  logic [WIDTH:0] br;
  logic [WIDTH-1:0] dn;
  fsub_result_t res_n, res_d, res_q;
  logic vld_d, vld_q;
  logic unused_res;
  assign br[0] = io.bin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fsub_bit u_bit (.a(io.a[i]), .b(io.b[i]), .bi(br[i]), .d(dn[i]), .bo(br[i+1]));
  end
  always_comb begin
    res_n = '0;
    res_n.bout = br[WIDTH];
    res_n.diff[WIDTH-1:0] = dn;
`ifdef FULL_SUBTRACTOR_OVF_EN
    res_n.ovf = (io.a[WIDTH-1] ^ io.b[WIDTH-1]) & (dn[WIDTH-1] ^ io.a[WIDTH-1]);
`endif
    res_d = io.in_valid ? res_n : res_q;
    vld_d = io.in_valid;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      res_q <= '0;
      vld_q <= 1'b0;
    end else begin
      res_q <= res_d;
      vld_q <= vld_d;
    end
  // Upper diff bits beyond WIDTH are always zero and never leave the block
  assign unused_res = ^res_q;
  assign io.out_valid = vld_q;
  assign io.diff = res_q.diff[WIDTH-1:0];
  assign io.bout = res_q.bout;
`ifdef FULL_SUBTRACTOR_OVF_EN
  assign io.ovf = res_q.ovf;
`endif
endmodule

// File: tb/tb_full_subtractor_core.sv
// tb_full_subtractor_core: directed and random checks at WIDTH 1, 8 and 16
module tb_full_subtractor_core;
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic bin;
    logic [7:0] d;
    logic bo;
    logic ov;
  } v8_t;
  logic clk;
  logic rst_n;
  int n_tests;
  int n_fail;
  v8_t v8 [6];
  logic [1:0] t1 [8];
  logic [16:0] m16;
  logic [15:0] exp_diff;
  logic exp_bout;
  logic exp_vld;
  full_subtractor_core_if #(.WIDTH(1)) f1 ();
  full_subtractor_core_if #(.WIDTH(8)) f8 ();
  full_subtractor_core_if #(.WIDTH(16)) f16 ();
  full_subtractor_core #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .io(f1.slave));
  full_subtractor_core #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .io(f8.slave));
  full_subtractor_core #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .io(f16.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk8(input string tag, input logic vld, input logic [7:0] d, input logic bo, input logic ov);
    chk({tag, " out_valid"}, f8.out_valid, vld);
    chk({tag, " diff"}, f8.diff, d);
    chk({tag, " bout"}, f8.bout, bo);
`ifdef FULL_SUBTRACTOR_OVF_EN
    chk({tag, " ovf"}, f8.ovf, ov);
`else
    if (ov === 1'bx) chk({tag, " ovf model"}, 1'b0, 1'b1);
`endif
  endtask
  initial begin
    n_tests = 0;
    n_fail = 0;
    t1 = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
    v8 = '{
      '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0},
      '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0},
      '{8'hA5, 8'h25, 1'b0, 8'h80, 1'b0, 1'b0},
      '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1},
      '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1},
      '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0}
    };
    {f1.in_valid, f1.a, f1.b, f1.bin} = '0;
    {f8.in_valid, f8.a, f8.b, f8.bin} = '0;
    {f16.in_valid, f16.a, f16.b, f16.bin} = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst w1 out_valid", f1.out_valid, 1'b0);
    chk("rst w1 diff", f1.diff, 1'b0);
    chk("rst w1 bout", f1.bout, 1'b0);
    chk8("rst w8", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst w16 out_valid", f16.out_valid, 1'b0);
    chk("rst w16 diff", f16.diff, 16'h0);
    chk("rst w16 bout", f16.bout, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      {f1.a, f1.b, f1.bin} = 3'(i);
      f1.in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("w1[%0d] out_valid", i), f1.out_valid, 1'b1);
      chk($sformatf("w1[%0d] diff", i), f1.diff, t1[i][1]);
      chk($sformatf("w1[%0d] bout", i), f1.bout, t1[i][0]);
    end
    f1.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      {f8.a, f8.b, f8.bin} = {v8[i].a, v8[i].b, v8[i].bin};
      f8.in_valid = 1'b1;
      @(negedge clk);
      chk8($sformatf("w8[%0d]", i), 1'b1, v8[i].d, v8[i].bo, v8[i].ov);
    end
    {f8.a, f8.b, f8.bin} = {8'h1F, 8'h10, 1'b0};
    @(negedge clk);
    chk8("gate load", 1'b1, 8'h0F, 1'b0, 1'b0);
    {f8.in_valid, f8.a, f8.b, f8.bin} = {1'b0, 8'h33, 8'h11, 1'b0};
    @(negedge clk);
    chk8("gate hold", 1'b0, 8'h0F, 1'b0, 1'b0);
    {f8.in_valid, f8.a, f8.b, f8.bin} = {1'b1, 8'h00, 8'h7F, 1'b1};
    @(negedge clk);
    chk8("pre rst", 1'b1, 8'h80, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk8("async rst", 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    chk8("rst held", 1'b0, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    {f8.a, f8.b, f8.bin} = {8'h20, 8'h30, 1'b1};
    @(negedge clk);
    chk8("post rst", 1'b1, 8'hEF, 1'b1, 1'b0);
    f8.in_valid = 1'b0;
    exp_vld = 1'b0;
    exp_diff = 16'h0;
    exp_bout = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      f16.a = 16'($urandom);
      f16.b = 16'($urandom);
      f16.bin = 1'($urandom_range(0, 1));
      f16.in_valid = 1'($urandom_range(0, 1));
      m16 = {1'b0, f16.a} - {1'b0, f16.b} - {16'h0, f16.bin};
      if (f16.in_valid) {exp_bout, exp_diff} = m16;
      exp_vld = f16.in_valid;
      @(negedge clk);
      chk("rnd out_valid", f16.out_valid, exp_vld);
      chk("rnd diff", f16.diff, exp_diff);
      chk("rnd bout", f16.bout, exp_bout);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
